// File: rtl/bulk_line_arbiter.sv
// Round-robin arbiter that multiplexes whole-line bulk requests from N masters onto one slave.
// Optional: define BULK_ARB_DUMP_PRIO_EN to let cache-dumping masters win arbitration first.
module bulk_line_arbiter #(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned ADDR_W    = 64,
   parameter int unsigned LINE_SIZE = 16,
   localparam int unsigned LW       = LINE_SIZE * DATA_W,
   localparam int unsigned SW       = LINE_SIZE * DATA_W / 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_PORTS-1:0]        m_req_valid_i,
   output logic [NUM_PORTS-1:0]        m_req_ready_o,
   input  logic [NUM_PORTS*ADDR_W-1:0] m_req_addr_i,
   input  logic [NUM_PORTS-1:0]        m_req_write_i,
   input  logic [NUM_PORTS*LW-1:0]     m_req_wdata_i,
   input  logic [NUM_PORTS*SW-1:0]     m_req_wstrb_i,
   input  logic [NUM_PORTS-1:0]        m_dumping_cache_i,
   output logic [NUM_PORTS-1:0]        m_resp_valid_o,
   output logic [LW-1:0]               m_resp_rdata_o,
   input  logic                        s_req_ready_i,
   output logic                        s_req_valid_o,
   output logic [ADDR_W-1:0]           s_req_addr_o,
   output logic                        s_req_write_o,
   output logic [LW-1:0]               s_req_wdata_o,
   output logic [SW-1:0]               s_req_wstrb_o,
   input  logic                        s_resp_valid_i,
   input  logic [LW-1:0]               s_resp_rdata_i,
   output logic                        s_dumping_cache_o
);

   localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]        grant_q, grant_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic                 write_q, write_d;
   logic [LW-1:0]        wdata_q, wdata_d;
   logic [SW-1:0]        wstrb_q, wstrb_d;
   logic                 dump_q, dump_d;
   logic [NUM_PORTS-1:0] resp_valid_q, resp_valid_d;
   logic [LW-1:0]        rdata_q, rdata_d;

   logic                 any_valid;
   logic                 win_found;
   logic [GW-1:0]        win_idx;
   logic [GW-1:0]        ptr_next;

   // Index of the master 'off' positions after 'base', wrapping at NUM_PORTS.
   function automatic logic [GW-1:0] rot_idx(input logic [GW-1:0] base, input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NUM_PORTS) s = s - NUM_PORTS;
      return GW'(s);
   endfunction

   assign any_valid = |m_req_valid_i;
   assign ptr_next  = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + GW'(1);

   // Winner select: first valid at or after rr_ptr, dumping masters first when enabled.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
`ifdef BULK_ARB_DUMP_PRIO_EN
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (!win_found && m_req_valid_i[rot_idx(rr_ptr_q, i)] &&
             m_dumping_cache_i[rot_idx(rr_ptr_q, i)]) begin
            win_found = 1'b1;
            win_idx   = rot_idx(rr_ptr_q, i);
         end
      end
`endif
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (!win_found && m_req_valid_i[rot_idx(rr_ptr_q, i)]) begin
            win_found = 1'b1;
            win_idx   = rot_idx(rr_ptr_q, i);
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (any_valid)      state_d = ST_ISSUE;
         ST_ISSUE: if (s_req_ready_i)  state_d = ST_WAIT;
         ST_WAIT:  if (s_resp_valid_i) state_d = ST_IDLE;
         default:                      state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      m_req_ready_o     = '0;
      s_req_valid_o     = 1'b0;
      s_dumping_cache_o = 1'b0;
      unique case (state_q)
         ST_IDLE:  if (win_found) m_req_ready_o = NUM_PORTS'(1) << win_idx;
         ST_ISSUE: begin
            s_req_valid_o     = 1'b1;
            s_dumping_cache_o = dump_q;
         end
         ST_WAIT:  s_dumping_cache_o = dump_q;
         default:  ;
      endcase
   end

   // Holding registers, response capture and pointer advance
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      grant_d      = grant_q;
      addr_d       = addr_q;
      write_d      = write_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      dump_d       = dump_q;
      resp_valid_d = '0;
      rdata_d      = rdata_q;
      if (state_q == ST_IDLE && win_found) begin
         grant_d = win_idx;
         addr_d  = m_req_addr_i[32'(win_idx) * ADDR_W +: ADDR_W];
         write_d = m_req_write_i[win_idx];
         wdata_d = m_req_wdata_i[32'(win_idx) * LW +: LW];
         wstrb_d = m_req_wstrb_i[32'(win_idx) * SW +: SW];
         dump_d  = m_dumping_cache_i[win_idx];
      end
      if (state_q == ST_WAIT && s_resp_valid_i) begin
         resp_valid_d = NUM_PORTS'(1) << grant_q;
         rdata_d      = s_resp_rdata_i;
         rr_ptr_d     = ptr_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q     <= '0;
         grant_q      <= '0;
         addr_q       <= '0;
         write_q      <= 1'b0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         dump_q       <= 1'b0;
         resp_valid_q <= '0;
         rdata_q      <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         grant_q      <= grant_d;
         addr_q       <= addr_d;
         write_q      <= write_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         dump_q       <= dump_d;
         resp_valid_q <= resp_valid_d;
         rdata_q      <= rdata_d;
      end
   end

   assign s_req_addr_o   = addr_q;
   assign s_req_write_o  = write_q;
   assign s_req_wdata_o  = wdata_q;
   assign s_req_wstrb_o  = wstrb_q;
   assign m_resp_valid_o = resp_valid_q;
   assign m_resp_rdata_o = rdata_q;

endmodule
